// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, line-level bit constants and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;

    // Parity bit that a transmitter appends for the given byte and parity type.
    function automatic logic calc_parity(input logic [7:0] data, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit sample counter with 3-sample majority vote around mid-bit.
// bit_value is valid in the decision cycle; no backpressure.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic rx,
    input  logic start,
    input  logic run,
    output logic bit_value,
    output logic decision,
    output logic bit_done
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] S_A    = CNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [CNT_W-1:0] S_B    = CNT_W'(OVERSAMPLE/2);
    localparam logic [CNT_W-1:0] S_DEC  = CNT_W'(OVERSAMPLE/2 + 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] s_q, s_d;
    logic [1:0]       samp_q, samp_d;

    always_comb begin
        s_d    = '0;
        samp_d = samp_q;
        // The start-detect cycle is s=0 of the start bit, so the first running cycle is s=1.
        if (start) begin
            s_d = CNT_W'(1);
        end else if (run) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + CNT_W'(1);
        end
        if (run && s_q == S_A) samp_d[0] = rx;
        if (run && s_q == S_B) samp_d[1] = rx;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s_q    <= '0;
            samp_q <= '0;
        end else begin
            s_q    <= s_d;
            samp_q <= samp_d;
        end
    end

    assign decision  = run && (s_q == S_DEC);
    assign bit_done  = run && (s_q == S_LAST);
    assign bit_value = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx) | (samp_q[1] & rx);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/8 data/optional parity/stop, strobes one cycle after the stop decision.
// No backpressure; UART_RX_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  Busy
);

    localparam int BC_W = $clog2(DATA_WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_WIDTH - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], RX_IN};

    always_ff @(posedge CLK) begin
        if (RST) sync_q <= 2'b11;
        else     sync_q <= sync_d;
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    uart_state_e           state_q, state_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic                  armed_q, armed_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  start_det, run;
    logic                  bit_value, decision, bit_done;

    assign run = (state_q != IDLE);

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .CLK       (CLK),
        .RST       (RST),
        .rx        (rx_s),
        .start     (start_det),
        .run       (run),
        .bit_value (bit_value),
        .decision  (decision),
        .bit_done  (bit_done)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        p_data_d  = p_data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bad_d = par_bad_q;
        armed_d   = armed_q | rx_s;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;
        start_det = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (armed_q && rx_s == START_BIT) begin
                    start_det = 1'b1;
                    state_d   = START;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_bad_d = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (decision && bit_value != START_BIT) state_d = IDLE;
                else if (bit_done)                      state_d = DATA;
            end
            DATA: begin
                if (decision) shreg_d = {bit_value, shreg_q[DATA_WIDTH-1:1]};
                if (bit_done) begin
                    if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
                    else                       bit_cnt_d = bit_cnt_q + BC_W'(1);
                end
            end
            PARITY: begin
                if (decision && bit_value != calc_parity(shreg_q, par_typ_q)) par_bad_d = 1'b1;
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                // Leave at mid-stop so a following start edge is never missed.
                if (decision) begin
                    state_d   = IDLE;
                    par_err_d = par_bad_q;
                    if (bit_value == STOP_BIT && !par_bad_q) begin
                        p_data_d = shreg_q;
                        valid_d  = 1'b1;
                    end
                    if (bit_value != STOP_BIT) begin
                        stp_err_d = 1'b1;
                        armed_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            p_data_q  <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad_q <= 1'b0;
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            p_data_q  <= p_data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_bad_q <= par_bad_d;
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign Busy       = run;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive end of the team's UART_TX serial frame.
- Frame format: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
- RX_IN is oversampled OVERSAMPLE times per bit; each bit is decided by a 3-sample majority vote.
- Output is a parallel byte with a one-cycle valid strobe plus parity/stop error strobes. Sits between the pad/line and the byte consumer (FIFO or register file).

Parameters:
- OVERSAMPLE, 8, CLK cycles per serial bit; legal values 4, 8, 16, 32.
- DATA_WIDTH, 8, data bits per frame; fixed at 8 for compatibility with UART_TX.

Ports:
- CLK  input  1  single clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- RX_IN  input  1  serial line; idles high.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  1 = odd parity, 0 = even parity.
- P_DATA  output  8  last correctly received byte.
- DATA_VALID  output  1  one-cycle strobe: P_DATA updated, frame good.
- PAR_ERR  output  1  one-cycle strobe: parity mismatch.
- STP_ERR  output  1  one-cycle strobe: stop bit sampled 0.
- Busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, Busy=0.
  - sample counter, bit counter and shift register cleared; armed=0.
- Arming: IDLE detects a start only when armed=1. armed sets after RX_IN is seen high for 1 cycle. This prevents false starts when reset releases mid-frame or on a low line.
- Bit timing:
  - sample counter s runs 0..OVERSAMPLE-1 per bit.
  - M = OVERSAMPLE/2. Samples are captured at s = M-1, M, M+1.
  - Bit value = majority of the 3 samples; decision is taken at s = M+1 (the decision cycle).
- States:
  - IDLE: if armed and RX_IN=0, that cycle is s=0 of the start bit → START. PAR_EN/PAR_TYP are latched at this point and held for the frame.
  - START: at the decision cycle, majority 1 → glitch, return to IDLE (no strobe). Majority 0 → at s=OVERSAMPLE-1 go to DATA.
  - DATA: 8 bits, shifted LSB first. After bit 7, go to PARITY if latched PAR_EN, else STOP.
  - PARITY: compare the decided bit with the computed parity.
    - Odd: bit = ~^data. Even: bit = ^data.
    - Mismatch sets an internal par_bad flag.
  - STOP: at the decision cycle, go straight to IDLE without waiting out the remainder of the stop bit, which allows back-to-back frames.
    - If stop=1 and !par_bad: P_DATA <= shift reg, DATA_VALID=1.
    - If par_bad: PAR_ERR=1.
    - If stop=0: STP_ERR=1.
    - Both error flags may pulse together. On any error, DATA_VALID stays 0 and P_DATA is held.
- Latency (cycle 0 = start-detect cycle): strobes are high in cycle (N*OVERSAMPLE + M + 2), where N = 10 with parity, 9 without. For OVERSAMPLE=8: cycle 86 with parity, 78 without.
- Strobes are exactly one cycle wide.
- Busy is 1 from the cycle after start detect through the STOP decision cycle.
- Stop error:
  - Returns to IDLE with armed cleared, so a held-low break produces one STP_ERR only.
  - Rearms when the line goes high.
- Reset asserted mid-frame: immediate IDLE, partial data discarded, no strobes.
- RX_IN is treated as already synchronous unless RX_SYNC_EN is defined.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer, reset to 1, before all logic. All latencies grow by 2 cycles (OVERSAMPLE=8 with parity: 88).
- Undefined: RX_IN is used directly, with the latencies above.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - constants: START_BIT=0, STOP_BIT=1, PAR_ODD=1, PAR_EVEN=0.
  - function for parity computation, shared with UART_TX.
- Sub-module uart_rx_sampler: sample counter, 3-sample capture and majority vote. Outputs bit_value, bit_done and decision strobe to the FSM.

Test Plan:
- 0xA5, PAR_EN=1, PAR_TYP=1, frame 0,1,0,1,0,0,1,0,1,1,1 at 8 cycles/bit → DATA_VALID at cycle 86, P_DATA=0xA5, no error.
- 0xA5, even parity, parity bit 0 → valid, P_DATA=0xA5. Same frame with parity bit 1 → PAR_ERR pulse, DATA_VALID=0, P_DATA held.
- 0x3C, PAR_EN=0, stop bit driven 0 → STP_ERR at cycle 78, DATA_VALID=0. Line then held low 200 cycles → no further strobes until the line returns high.
- RX_IN low pulse of 2 cycles in idle → no strobes, Busy returns to 0 by cycle 6. A following real frame of 0x81 → valid.
- Back-to-back frames 0x00 then 0xFF, no idle gap, parity off → two DATA_VALID pulses 80 cycles apart.
- RST asserted at cycle 40 of a frame → outputs 0 next cycle. Resume with line high, then send 0x5A → valid 0x5A.
